// File: rtl/mm_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mm_pkg : shared matrix-multiply datapath constants and sizing helper. Rev 1.0
// ---------------------------------------------------------------------------
package mm_pkg;

  localparam int DEF_WIDTH     = 32;
  localparam int DEF_RES_WIDTH = 37;
  localparam int DEF_LENGTH    = 32;

  // Smallest accumulator width that can hold the sum of `length` unsigned terms.
  function automatic int res_width_min(input int width, input int length);
    return width + $clog2(length);
  endfunction

endpackage
`default_nettype wire

// File: rtl/noOverflowAdd.sv
`default_nettype none
// ---------------------------------------------------------------------------
// noOverflowAdd : unsigned add of a narrower operand into a wide one. Rev 1.0
// ---------------------------------------------------------------------------
module noOverflowAdd #(
  parameter int WIDTH_A = 37,
  parameter int WIDTH_B = 32
) (
  input  logic [WIDTH_A-1:0] a_i,
  input  logic [WIDTH_B-1:0] b_i,
  output logic [WIDTH_A-1:0] sum_o
);

  generate
    if (WIDTH_A < WIDTH_B) begin : g_bad_width
      $fatal(1, "noOverflowAdd: WIDTH_A must be >= WIDTH_B");
    end
  endgenerate

  // The caller sizes WIDTH_A with enough headroom that no carry is lost.
  assign sum_o = a_i + WIDTH_A'(b_i);

endmodule
`default_nettype wire

// File: rtl/dot_product_accumulator.sv
`default_nettype none
// ---------------------------------------------------------------------------
// dot_product_accumulator : sums LENGTH streamed products into one result. Rev 1.0
// ---------------------------------------------------------------------------
module dot_product_accumulator
  import mm_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int RES_WIDTH = DEF_RES_WIDTH,
  parameter int LENGTH    = DEF_LENGTH
) (
  input  logic                 Clock,
  input  logic                 Reset_n,
  input  logic                 clear,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [RES_WIDTH-1:0] out_sum
);

  localparam int CNT_W = (LENGTH > 1) ? $clog2(LENGTH) : 1;

  generate
    if (LENGTH < 1) begin : g_bad_length
      $fatal(1, "dot_product_accumulator: LENGTH must be >= 1");
    end
    if (RES_WIDTH < res_width_min(WIDTH, LENGTH)) begin : g_bad_res_width
      $fatal(1, "dot_product_accumulator: RES_WIDTH too narrow for WIDTH and LENGTH");
    end
  endgenerate

  logic [RES_WIDTH-1:0] acc_q, acc_d;
  logic [RES_WIDTH-1:0] sum_q, sum_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 valid_q, valid_d;
  logic [RES_WIDTH-1:0] add_sum;
  logic                 last;
  logic                 in_xfer;
  logic                 out_xfer;

  noOverflowAdd #(
    .WIDTH_A (RES_WIDTH),
    .WIDTH_B (WIDTH)
  ) u_add (
    .a_i   (acc_q),
    .b_i   (in_data),
    .sum_o (add_sum)
  );

  assign last     = (cnt_q == CNT_W'(LENGTH - 1));
  // Only the closing term needs the output slot, so only it can stall.
  assign in_ready = !clear && !(last && valid_q && !out_ready);
  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = valid_q && out_ready;

  always_comb begin
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    valid_d = valid_q;
    if (out_xfer) valid_d = 1'b0;
    if (clear) begin
      acc_d = '0;
      cnt_d = '0;
    end else if (in_xfer) begin
      if (last) begin
        sum_d   = add_sum;
        valid_d = 1'b1;
        acc_d   = '0;
        cnt_d   = '0;
      end else begin
        acc_d = add_sum;
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      acc_q   <= '0;
      cnt_q   <= '0;
      sum_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      valid_q <= valid_d;
    end
  end

  assign out_valid = valid_q;
  assign out_sum   = sum_q;

endmodule
`default_nettype wire

// File: tb/tb_dot_product_accumulator.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_dot_product_accumulator : randomized and directed checks against a term-list model. Rev 1.0
// ---------------------------------------------------------------------------
module tb_dot_product_accumulator;

  localparam int L = 4;

  logic        Clock = 1'b0;
  logic        Reset_n = 1'b0;
  logic        clear = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [36:0] out_sum;

  logic        in_valid2 = 1'b0;
  logic        in_ready2;
  logic [31:0] in_data2 = '0;
  logic        out_valid2;
  logic        out_ready2 = 1'b0;
  logic [36:0] out_sum2;

  int errors = 0;
  int checks = 0;

  logic [31:0] terms[$];
  logic        m_pend;
  logic [36:0] m_val;

  always #5 Clock = ~Clock;

  dot_product_accumulator #(.WIDTH(32), .RES_WIDTH(37), .LENGTH(L)) dut (
    .Clock(Clock), .Reset_n(Reset_n), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum)
  );

  dot_product_accumulator #(.WIDTH(32), .RES_WIDTH(37), .LENGTH(1)) dut1 (
    .Clock(Clock), .Reset_n(Reset_n), .clear(1'b0),
    .in_valid(in_valid2), .in_ready(in_ready2), .in_data(in_data2),
    .out_valid(out_valid2), .out_ready(out_ready2), .out_sum(out_sum2)
  );

  task automatic model_reset();
    terms.delete();
    m_pend = 1'b0;
    m_val  = '0;
  endtask

  // Applies one cycle of inputs, advances one clock and updates the model.
  task automatic tick(input logic v, input logic [31:0] d, input logic c, input logic r,
                      output logic obs_rdy, output logic exp_rdy);
    logic        in_x;
    logic        out_x;
    logic [36:0] s;
    in_valid = v; in_data = d; clear = c; out_ready = r;
    #1;
    obs_rdy = in_ready;
    exp_rdy = !c && !((terms.size() == L - 1) && m_pend && !r);
    in_x  = v && exp_rdy;
    out_x = m_pend && r;
    if (out_x) m_pend = 1'b0;
    if (c) terms.delete();
    else if (in_x) begin
      terms.push_back(d);
      if (terms.size() == L) begin
        s = '0;
        foreach (terms[i]) s = s + 37'(terms[i]);
        m_val  = s;
        m_pend = 1'b1;
        terms.delete();
      end
    end
    @(posedge Clock);
    #1;
    in_valid = 1'b0; clear = 1'b0;
  endtask

  task automatic test_reset();
    Reset_n = 1'b0;
    model_reset();
    repeat (3) @(posedge Clock);
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b want=0", out_valid); end
    checks++; if (out_sum !== 37'd0) begin errors++; $display("FAIL reset_sum got=%0h want=0", out_sum); end
    Reset_n = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
  endtask

  task automatic test_basic();
    logic o, e;
    for (int i = 1; i <= 4; i++) begin
      tick(1'b1, 32'(i), 1'b0, 1'b1, o, e);
      checks++; if (o !== 1'b1) begin errors++; $display("FAIL basic_rdy[%0d] got=%b want=1", i, o); end
      if (i < 4) begin
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid[%0d] got=%b want=0", i, out_valid); end
      end
    end
    checks++; if (out_valid !== 1'b1 || out_sum !== 37'd10)
      begin errors++; $display("FAIL basic_sum got=%b/%0d want=1/10", out_valid, out_sum); end
    tick(1'b0, 32'd0, 1'b0, 1'b1, o, e);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_one_cycle got=%b want=0", out_valid); end
  endtask

  task automatic test_max();
    logic o, e;
    repeat (4) tick(1'b1, 32'hFFFF_FFFF, 1'b0, 1'b1, o, e);
    checks++; if (out_valid !== 1'b1 || out_sum !== 37'h3_FFFF_FFFC)
      begin errors++; $display("FAIL max_sum got=%b/%0h want=1/3fffffffc", out_valid, out_sum); end
    tick(1'b0, 32'd0, 1'b0, 1'b1, o, e);
  endtask

  task automatic test_back_to_back();
    logic o, e;
    int   xfers = 0;
    for (int i = 1; i <= 8; i++) begin
      tick(1'b1, 32'(i), 1'b0, 1'b1, o, e);
      if (o) xfers++;
      if (i == 4) begin
        checks++; if (out_valid !== 1'b1 || out_sum !== 37'd10)
          begin errors++; $display("FAIL b2b_first got=%b/%0d want=1/10", out_valid, out_sum); end
      end
      if (i == 5) begin
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain got=%b want=0", out_valid); end
      end
    end
    checks++; if (out_valid !== 1'b1 || out_sum !== 37'd26)
      begin errors++; $display("FAIL b2b_second got=%b/%0d want=1/26", out_valid, out_sum); end
    checks++; if (xfers != 8) begin errors++; $display("FAIL b2b_xfers got=%0d want=8", xfers); end
    tick(1'b0, 32'd0, 1'b0, 1'b1, o, e);
  endtask

  task automatic test_stall();
    logic o, e;
    for (int i = 1; i <= 4; i++) tick(1'b1, 32'(i), 1'b0, 1'b0, o, e);
    repeat (3) tick(1'b1, 32'd5, 1'b0, 1'b0, o, e);
    tick(1'b1, 32'd5, 1'b0, 1'b0, o, e);
    checks++; if (o !== 1'b0) begin errors++; $display("FAIL stall_rdy got=%b want=0", o); end
    checks++; if (out_valid !== 1'b1 || out_sum !== 37'd10)
      begin errors++; $display("FAIL stall_hold got=%b/%0d want=1/10", out_valid, out_sum); end
    tick(1'b1, 32'd5, 1'b0, 1'b1, o, e);
    checks++; if (o !== 1'b1) begin errors++; $display("FAIL stall_release got=%b want=1", o); end
    checks++; if (out_valid !== 1'b1 || out_sum !== 37'd20)
      begin errors++; $display("FAIL stall_sum got=%b/%0d want=1/20", out_valid, out_sum); end
    tick(1'b0, 32'd0, 1'b0, 1'b1, o, e);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stall_drain got=%b want=0", out_valid); end
  endtask

  task automatic test_clear();
    logic o, e;
    tick(1'b1, 32'd1, 1'b0, 1'b1, o, e);
    tick(1'b1, 32'd2, 1'b0, 1'b1, o, e);
    tick(1'b1, 32'd9, 1'b1, 1'b1, o, e);
    checks++; if (o !== 1'b0) begin errors++; $display("FAIL clear_rdy got=%b want=0", o); end
    repeat (4) tick(1'b1, 32'd3, 1'b0, 1'b1, o, e);
    checks++; if (out_valid !== 1'b1 || out_sum !== 37'd12)
      begin errors++; $display("FAIL clear_sum got=%b/%0d want=1/12", out_valid, out_sum); end
    tick(1'b0, 32'd0, 1'b0, 1'b1, o, e);
  endtask

  task automatic test_reset_mid();
    logic o, e;
    for (int i = 1; i <= 4; i++) tick(1'b1, 32'(i), 1'b0, 1'b0, o, e);
    tick(1'b1, 32'd7, 1'b0, 1'b0, o, e);
    tick(1'b1, 32'd7, 1'b0, 1'b0, o, e);
    Reset_n = 1'b0;
    model_reset();
    #1;
    checks++; if (out_valid !== 1'b0 || out_sum !== 37'd0)
      begin errors++; $display("FAIL midreset_clear got=%b/%0d want=0/0", out_valid, out_sum); end
    @(negedge Clock);
    Reset_n = 1'b1;
    @(posedge Clock);
    #1;
    repeat (4) tick(1'b1, 32'd1, 1'b0, 1'b1, o, e);
    checks++; if (out_valid !== 1'b1 || out_sum !== 37'd4)
      begin errors++; $display("FAIL midreset_sum got=%b/%0d want=1/4", out_valid, out_sum); end
    tick(1'b0, 32'd0, 1'b0, 1'b1, o, e);
  endtask

  task automatic test_random();
    logic        o, e, v, c, r;
    logic [31:0] d;
    for (int i = 0; i < 400; i++) begin
      v = ($urandom_range(0, 3) != 0);
      c = ($urandom_range(0, 15) == 0);
      r = $urandom_range(0, 1) == 1;
      d = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : 32'($urandom);
      tick(v, d, c, r, o, e);
      checks++; if (o !== e) begin errors++; $display("FAIL rand_rdy[%0d] got=%b want=%b", i, o, e); end
      checks++; if (out_valid !== m_pend || (m_pend && out_sum !== m_val))
        begin errors++; $display("FAIL rand_out[%0d] got=%b/%0h want=%b/%0h", i, out_valid, out_sum, m_pend, m_val); end
    end
    tick(1'b0, 32'd0, 1'b0, 1'b1, o, e);
  endtask

  task automatic test_length1();
    logic [31:0] d;
    out_ready2 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      d = 32'($urandom);
      in_valid2 = 1'b1;
      in_data2  = d;
      #1;
      checks++; if (in_ready2 !== 1'b1) begin errors++; $display("FAIL len1_rdy[%0d] got=%b want=1", i, in_ready2); end
      @(posedge Clock);
      #1;
      checks++; if (out_valid2 !== 1'b1 || out_sum2 !== {5'd0, d})
        begin errors++; $display("FAIL len1_sum[%0d] got=%b/%0h want=1/%0h", i, out_valid2, out_sum2, d); end
    end
    in_valid2 = 1'b0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_basic();
    test_max();
    test_back_to_back();
    test_stall();
    test_clear();
    test_reset_mid();
    test_random();
    test_length1();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
